fpu_exception_ctrl: RTL and testbench

Parametrised next-generation FPU exception controller for the FPU8087 core. It latches sticky exception flags and drives the interrupt through an acknowledge-aware state machine. It supports two signalling modes: 8087 sticky INT, and 387-style mask-tracking. It also records each faulting operation into a readable exception log FIFO. It sits between the arithmetic unit/microsequencer and the CPU-side interrupt and status-word logic.

---
 rtl/fpu_exc_pkg.sv | 26 ++
 rtl/fpu_exc_log_fifo.sv | 79 +++++++
 rtl/fpu_exception_ctrl.sv | 151 +++++++++++++++
 tb/tb_fpu_exception_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_exc_pkg.sv
// Shared types for the FPU exception controller: FSM encoding, flag indices, log sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_exc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACKED  = 2'd2
    } exc_state_t;

    // Exception flag bit positions; lower index means higher priority.
    localparam int EXC_INVALID   = 0;
    localparam int EXC_DENORMAL  = 1;
    localparam int EXC_ZERO_DIV  = 2;
    localparam int EXC_OVERFLOW  = 3;
    localparam int EXC_UNDERFLOW = 4;
    localparam int EXC_PRECISION = 5;

    // Width of one stored log entry; without IP capture only the flags are kept.
    function automatic int log_entry_w(input int addr_w, input int opc_w,
                                       input int num_exc, input bit ip_capture);
        return ip_capture ? (addr_w + opc_w + num_exc) : num_exc;
    endfunction

endpackage

// File: rtl/fpu_exc_log_fifo.sv
// Synchronous exception-log FIFO with flush, drop-on-full, sticky overflow and registered read.
// Latency: rd_data/rd_valid appear one cycle after an accepted rd_en.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module fpu_exc_log_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = wr_en && (!full || do_pop);

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, overflow and registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_en && !do_push) begin
                overflow <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_exception_ctrl.sv
// FPU exception controller: sticky flags, ack-aware INT FSM (sticky or mask-tracking), fault log.
// Latency: int_out/flags one cycle after exc_latch; log read data one cycle after log_rd_en.
// Backpressure: none; log drops on full (sticky log_overflow). FPU_EXC_IP_CAPTURE_EN stores ip/opcode.
module fpu_exception_ctrl
    import fpu_exc_pkg::*;
#(
    parameter int NUM_EXC         = 6,
    parameter int LOG_DEPTH       = 4,
    parameter int ADDR_W          = 20,
    parameter int OPC_W           = 11,
    parameter int INT_ACTIVE_HIGH = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_EXC-1:0]               exc_in,
    input  logic [NUM_EXC-1:0]               exc_mask,
    input  logic                             exc_latch,
    input  logic [ADDR_W-1:0]                op_ip,
    input  logic [OPC_W-1:0]                 op_opcode,
    input  logic                             exc_clear,
    input  logic                             mask_track,
    input  logic                             int_ack,
    output logic                             int_out,
    output logic                             exc_pending,
    output logic [NUM_EXC-1:0]               status_flags,
    output logic                             top_exc_valid,
    output logic [$clog2(NUM_EXC)-1:0]       top_exc_idx,
    input  logic                             log_rd_en,
    output logic [ADDR_W+OPC_W+NUM_EXC-1:0]  log_rd_data,
    output logic                             log_rd_valid,
    output logic [$clog2(LOG_DEPTH):0]       log_count,
    output logic                             log_overflow
);

    localparam int   IDX_W   = $clog2(NUM_EXC);
    localparam logic INT_ON  = (INT_ACTIVE_HIGH != 0);
    localparam logic INT_OFF = ~INT_ON;
`ifdef FPU_EXC_IP_CAPTURE_EN
    localparam int   LOG_W   = log_entry_w(ADDR_W, OPC_W, NUM_EXC, 1'b1);
`else
    localparam int   LOG_W   = log_entry_w(ADDR_W, OPC_W, NUM_EXC, 1'b0);
`endif

    exc_state_t         state;
    exc_state_t         state_nxt;
    logic [NUM_EXC-1:0] unmasked_flags;
    logic               new_unmasked;
    logic               log_push;
    logic [LOG_W-1:0]   log_wr_data;
    logic [LOG_W-1:0]   log_rd_entry;

    assign unmasked_flags = status_flags & ~exc_mask;
    assign new_unmasked   = exc_latch && |(exc_in & ~exc_mask);
    assign top_exc_valid  = |unmasked_flags;
    assign exc_pending    = (state != IDLE);
    assign log_push       = exc_latch && |exc_in && !exc_clear;

    // Highest-priority (lowest index) unmasked latched flag.
    always_comb begin
        top_exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (unmasked_flags[i]) begin
                top_exc_idx = IDX_W'(i);
            end
        end
    end

    // Sticky flags; clear beats a same-cycle latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_flags <= '0;
        end else if (exc_clear) begin
            status_flags <= '0;
        end else if (exc_latch) begin
            status_flags <= status_flags | exc_in;
        end
    end

    // Next-state for the interrupt handshake; mask changes only matter in mask-tracking mode.
    always_comb begin
        state_nxt = state;
        if (exc_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (new_unmasked || (mask_track && top_exc_valid)) begin
                        state_nxt = ASSERT;
                    end
                end
                ASSERT: begin
                    // A fresh unmasked fault keeps INT raised even if acked this cycle.
                    if (new_unmasked) begin
                        state_nxt = ASSERT;
                    end else if (mask_track && !top_exc_valid) begin
                        state_nxt = IDLE;
                    end else if (int_ack) begin
                        state_nxt = ACKED;
                    end
                end
                ACKED: begin
                    if (new_unmasked) begin
                        state_nxt = ASSERT;
                    end else if (mask_track && !top_exc_valid) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register with registered, polarity-adjusted interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            int_out <= INT_OFF;
        end else begin
            state   <= state_nxt;
            int_out <= (state_nxt == ASSERT) ? INT_ON : INT_OFF;
        end
    end

`ifdef FPU_EXC_IP_CAPTURE_EN
    assign log_wr_data = {op_ip, op_opcode, exc_in};
    assign log_rd_data = log_rd_entry;
`else
    // Flags-only log: ip/opcode are not stored and read back as zero.
    logic unused_ip_opc;
    assign unused_ip_opc = ^{op_ip, op_opcode};
    assign log_wr_data   = exc_in;
    assign log_rd_data   = {{(ADDR_W + OPC_W){1'b0}}, log_rd_entry};
`endif

    fpu_exc_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (exc_clear),
        .wr_en    (log_push),
        .wr_data  (log_wr_data),
        .rd_en    (log_rd_en),
        .rd_data  (log_rd_entry),
        .rd_valid (log_rd_valid),
        .count    (log_count),
        .overflow (log_overflow)
    );

endmodule

// File: tb/tb_fpu_exception_ctrl.sv
// Bench for fpu_exception_ctrl: directed scenarios plus random traffic against a reference model.
// Two instances share stimulus: active-high and active-low INT polarity.
module tb_fpu_exception_ctrl;

    localparam int NUM_EXC   = 6;
    localparam int LOG_DEPTH = 4;
    localparam int ADDR_W    = 20;
    localparam int OPC_W     = 11;
    localparam int LW        = ADDR_W + OPC_W + NUM_EXC;

    logic               clk;
    logic               reset_n;
    logic [NUM_EXC-1:0] exc_in;
    logic [NUM_EXC-1:0] exc_mask;
    logic               exc_latch;
    logic [ADDR_W-1:0]  op_ip;
    logic [OPC_W-1:0]   op_opcode;
    logic               exc_clear;
    logic               mask_track;
    logic               int_ack;
    logic               log_rd_en;

    logic               int_hi, pend_hi, tv_hi, rv_hi, ovf_hi;
    logic [NUM_EXC-1:0] flags_hi;
    logic [2:0]         ti_hi;
    logic [LW-1:0]      rdat_hi;
    logic [2:0]         cnt_hi;

    logic               int_lo, pend_lo, tv_lo, rv_lo, ovf_lo;
    logic [NUM_EXC-1:0] flags_lo;
    logic [2:0]         ti_lo;
    logic [LW-1:0]      rdat_lo;
    logic [2:0]         cnt_lo;

    fpu_exception_ctrl dut_hi (
        .clk(clk), .reset_n(reset_n), .exc_in(exc_in), .exc_mask(exc_mask),
        .exc_latch(exc_latch), .op_ip(op_ip), .op_opcode(op_opcode),
        .exc_clear(exc_clear), .mask_track(mask_track), .int_ack(int_ack),
        .int_out(int_hi), .exc_pending(pend_hi), .status_flags(flags_hi),
        .top_exc_valid(tv_hi), .top_exc_idx(ti_hi), .log_rd_en(log_rd_en),
        .log_rd_data(rdat_hi), .log_rd_valid(rv_hi), .log_count(cnt_hi),
        .log_overflow(ovf_hi)
    );

    fpu_exception_ctrl #(.INT_ACTIVE_HIGH(0)) dut_lo (
        .clk(clk), .reset_n(reset_n), .exc_in(exc_in), .exc_mask(exc_mask),
        .exc_latch(exc_latch), .op_ip(op_ip), .op_opcode(op_opcode),
        .exc_clear(exc_clear), .mask_track(mask_track), .int_ack(int_ack),
        .int_out(int_lo), .exc_pending(pend_lo), .status_flags(flags_lo),
        .top_exc_valid(tv_lo), .top_exc_idx(ti_lo), .log_rd_en(log_rd_en),
        .log_rd_data(rdat_lo), .log_rd_valid(rv_lo), .log_count(cnt_lo),
        .log_overflow(ovf_lo)
    );

    typedef struct packed {
        logic               int_h;
        logic               int_l;
        logic               pend;
        logic [NUM_EXC-1:0] flags;
        logic               tv;
        logic [2:0]         ti;
        logic [2:0]         cnt;
        logic               ovf;
        logic               rv;
        logic [LW-1:0]      rdat;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model state: INT raised / acknowledged, flags, log contents.
    bit            m_raised;
    bit            m_acked;
    logic [5:0]    m_flags;
    logic [LW-1:0] m_log[$];
    logic          m_ovf;
    logic          m_rv;
    logic [LW-1:0] m_rdat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [LW-1:0] entry_of(logic [ADDR_W-1:0] ip, logic [OPC_W-1:0] opc,
                                               logic [NUM_EXC-1:0] e);
`ifdef FPU_EXC_IP_CAPTURE_EN
        return {ip, opc, e};
`else
        logic [ADDR_W+OPC_W-1:0] z;
        z = '0;
        return {z, e};
`endif
    endfunction

    // Advance the model by one clock edge using the currently driven inputs; return expected outputs.
    function automatic snap_t model_step();
        snap_t s;
        logic [5:0] vis, lowbit;
        bit unm_now, fresh;
        if (!reset_n) begin
            m_raised = 0; m_acked = 0; m_flags = '0; m_log.delete();
            m_ovf = 0; m_rv = 0; m_rdat = '0;
        end else if (exc_clear) begin
            m_raised = 0; m_acked = 0; m_flags = '0; m_log.delete();
            m_ovf = 0; m_rv = 0;
        end else begin
            unm_now = (m_flags & ~exc_mask) != 0;
            fresh   = exc_latch && ((exc_in & ~exc_mask) != 0);
            if (fresh) begin
                m_raised = 1; m_acked = 0;
            end else if ((m_raised || m_acked) && mask_track && !unm_now) begin
                m_raised = 0; m_acked = 0;
            end else if (!m_raised && !m_acked && mask_track && unm_now) begin
                m_raised = 1;
            end else if (m_raised && int_ack) begin
                m_raised = 0; m_acked = 1;
            end
            m_rv = 0;
            if (log_rd_en && m_log.size() > 0) begin
                m_rdat = m_log.pop_front();
                m_rv   = 1;
            end
            if (exc_latch && exc_in != 0) begin
                if (m_log.size() < LOG_DEPTH) m_log.push_back(entry_of(op_ip, op_opcode, exc_in));
                else m_ovf = 1;
            end
            if (exc_latch) m_flags = m_flags | exc_in;
        end
        vis    = m_flags & ~exc_mask;
        lowbit = vis & (~vis + 6'd1);
        s.int_h = m_raised;
        s.int_l = !m_raised;
        s.pend  = m_raised || m_acked;
        s.flags = m_flags;
        s.tv    = vis != 0;
        s.ti    = 3'($clog2(lowbit));
        s.cnt   = 3'(m_log.size());
        s.ovf   = m_ovf;
        s.rv    = m_rv;
        s.rdat  = m_rdat;
        return s;
    endfunction

    // One cycle: predict the next edge, queue the prediction, move to the next falling edge.
    task automatic tick(int n = 1);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_step());
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        exc_latch = 0; exc_clear = 0; int_ack = 0; log_rd_en = 0;
    endtask

    task automatic do_latch(logic [5:0] e, logic [ADDR_W-1:0] ip);
        exc_in = e; op_ip = ip; op_opcode = OPC_W'(ip) ^ 11'h5a5; exc_latch = 1;
        tick();
        exc_latch = 0;
    endtask

    // Monitor: compare DUT outputs against the queued prediction shortly after each edge.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{int_hi, int_lo, pend_hi, flags_hi, tv_hi, ti_hi, cnt_hi, ovf_hi, rv_hi, rdat_hi};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got int=%b/%b pend=%b flags=%b tv=%b ti=%0d cnt=%0d ovf=%b rv=%b rdat=%h exp int=%b/%b pend=%b flags=%b tv=%b ti=%0d cnt=%0d ovf=%b rv=%b rdat=%h",
                             $time, a.int_h, a.int_l, a.pend, a.flags, a.tv, a.ti, a.cnt, a.ovf, a.rv, a.rdat,
                             e.int_h, e.int_l, e.pend, e.flags, e.tv, e.ti, e.cnt, e.ovf, e.rv, e.rdat);
                end
            end
        end
    end

    task automatic direct_check(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        reset_n = 0; exc_in = '0; exc_mask = '1; op_ip = '0; op_opcode = '0;
        mask_track = 0;
        quiet();
        @(negedge clk);
        tick(2);
        reset_n = 1;
        tick();

        // Single unmasked zero-divide, then ack, then re-signal with invalid.
        exc_mask = 6'b111011;
        do_latch(6'b000100, 20'd1);
        tick();
        int_ack = 1; tick(); int_ack = 0;
        tick();
        exc_mask = 6'b111010;
        do_latch(6'b000001, 20'd2);
        tick();

        // Asynchronous reset while INT is asserted.
        reset_n = 0;
        #1;
        direct_check("async_int_hi", 8'(int_hi), 8'd0);
        direct_check("async_int_lo", 8'(int_lo), 8'd1);
        direct_check("async_log_count", 8'(cnt_hi), 8'd0);
        tick();
        reset_n = 1;
        tick();

        // Mask tracking: masked overflow becomes visible, then hidden again.
        mask_track = 1; exc_mask = 6'b111111;
        do_latch(6'b001000, 20'd3);
        exc_mask = 6'b110111; tick(2);
        exc_mask = 6'b111111; tick(2);
        mask_track = 0;
        exc_mask = 6'b110111; tick(2);
        exc_mask = 6'b111111; tick(2);

        // Clear and latch together: clear wins.
        exc_clear = 1; exc_in = 6'b111111; exc_latch = 1; exc_mask = '0;
        tick();
        quiet(); exc_mask = '1;
        tick();

        // Overflow the log, then drain it past empty.
        for (int i = 1; i <= 5; i++) do_latch(6'(i), 20'(i));
        log_rd_en = 1; tick(5); log_rd_en = 0;
        tick();

        // Full log with simultaneous push and pop.
        for (int i = 6; i <= 9; i++) do_latch(6'(i), 20'(i));
        log_rd_en = 1; do_latch(6'b010000, 20'd10); log_rd_en = 0;
        tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) mask_track = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) exc_mask = 6'($urandom);
            exc_latch = ($urandom_range(0, 2) == 0);
            exc_in    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'(1 << $urandom_range(0, 5)) | 6'($urandom & $urandom);
            op_ip     = 20'($urandom);
            op_opcode = 11'($urandom);
            exc_clear = ($urandom_range(0, 24) == 0);
            int_ack   = ($urandom_range(0, 3) == 0);
            log_rd_en = ($urandom_range(0, 2) == 0);
            tick();
        end
        quiet();
        tick(2);

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
